// File: rtl/relprime_engine.sv
// Handshaked relative-prime coprocessor: finds the smallest m >= 2 with gcd(m, n) == 1
// using one subtractive-Euclid step per clock, and reports an error if none fits in WIDTH bits.
`timescale 1ns/1ps

module relprime_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CYC_W = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic [CYC_W-1:0] cycles
);

  localparam logic [WIDTH-1:0] M_MAX   = {WIDTH{1'b1}};
  localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_GCD   = 2'd2,
    S_CHECK = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             error_q, error_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;

  // Next-state and datapath; done_d is the only signal that does not hold by default.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    m_d      = m_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    error_d  = error_q;
    cycles_d = cycles_q;

    if (busy_q && (cycles_q != CYC_MAX)) begin
      cycles_d = cycles_q + CYC_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d      = n_in;
          m_d      = WIDTH'(2);
          cycles_d = '0;
          error_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        a_d     = n_q;
        b_d     = m_q;
        state_d = S_GCD;
      end
      S_GCD: begin
        if (b_q == '0) begin
          state_d = S_CHECK;
        end else if (a_q >= b_q) begin
          a_d = a_q - b_q;
        end else begin
          a_d = b_q;
          b_d = a_q;
        end
      end
      S_CHECK: begin
        // a_q holds gcd(n, m) here
        if (a_q == WIDTH'(1)) begin
          result_d = m_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else if (m_q == M_MAX) begin
          error_d  = 1'b1;
          result_d = '0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          m_d     = m_q + WIDTH'(1);
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      m_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      m_q      <= m_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      error_q  <= error_d;
      cycles_q <= cycles_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign error  = error_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_relprime_engine.sv
// Scoreboard bench for relprime_engine: a 16-bit and an 8-bit instance share clock and reset;
// expected results are queued at start time and compared when done pulses.
`timescale 1ns/1ps

module tb_relprime_engine;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        start16, start8;
  logic [15:0] n16;
  logic [7:0]  n8;
  logic        busy16, done16, err16;
  logic [15:0] res16;
  logic [31:0] cyc16;
  logic        busy8, done8, err8;
  logic [7:0]  res8;
  logic [31:0] cyc8;

  relprime_engine #(.WIDTH(16), .CYC_W(32)) u_dut16 (
    .CLK(CLK), .RESET_N(RESET_N), .start(start16), .n_in(n16),
    .busy(busy16), .done(done16), .result(res16), .error(err16), .cycles(cyc16)
  );

  relprime_engine #(.WIDTH(8), .CYC_W(32)) u_dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .start(start8), .n_in(n8),
    .busy(busy8), .done(done8), .result(res8), .error(err8), .cycles(cyc8)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] res;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   sel8     = 1'b0;

  logic        o_busy, o_done, o_err;
  logic [15:0] o_res;
  logic [31:0] o_cyc;

  always_comb begin
    o_busy = sel8 ? busy8 : busy16;
    o_done = sel8 ? done8 : done16;
    o_err  = sel8 ? err8  : err16;
    o_res  = sel8 ? {8'h00, res8} : res16;
    o_cyc  = sel8 ? cyc8  : cyc16;
  end

  function automatic int unsigned gcd_mod(input int unsigned x, input int unsigned y);
    int unsigned p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Reference: answer from modulo gcd, clock count from the subtractive schedule
  // (LOAD + one cycle per step + the b==0 cycle + CHECK, per candidate m).
  function automatic exp_t model(input int unsigned n, input int unsigned w);
    exp_t        e;
    int unsigned maxm, a, b, t;
    longint unsigned cyc;
    maxm  = (1 << w) - 1;
    cyc   = 0;
    e.res = 16'h0;
    e.err = 1'b1;
    for (int unsigned m = 2; m <= maxm; m++) begin
      a = n;
      b = m;
      cyc += 1;
      while (b != 0) begin
        if (a >= b) a = a - b;
        else begin
          t = a; a = b; b = t;
        end
        cyc += 1;
      end
      cyc += 2;
      if (gcd_mod(m, n) == 1) begin
        e.res = 16'(m);
        e.err = 1'b0;
        break;
      end
    end
    e.cyc = 32'(cyc);
    return e;
  endfunction

  task automatic start_job(input bit is8, input int unsigned n);
    @(negedge CLK);
    if (is8) begin
      start8 = 1'b1; n8 = 8'(n);
    end else begin
      start16 = 1'b1; n16 = 16'(n);
    end
    sb.push_back(model(n, is8 ? 8 : 16));
    @(negedge CLK);
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  // Waits on the selected instance; returns at the negedge where done is high.
  task automatic wait_done(input int budget, output bit to, output bit mono, output bit ovl);
    logic [31:0] prev;
    to   = 1'b1;
    mono = 1'b1;
    ovl  = 1'b0;
    prev = o_cyc;
    for (int i = 0; i < budget; i++) begin
      if (o_busy && o_done) ovl = 1'b1;
      if (o_busy) begin
        if (o_cyc < prev) mono = 1'b0;
        prev = o_cyc;
      end
      if (o_done) begin
        to = 1'b0;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    start16 = 1'b0; start8 = 1'b0; n16 = '0; n8 = '0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({busy16, done16, err16, res16, cyc16} !== '0)
      $display("FAIL reset16 got busy=%b done=%b err=%b res=%0d cyc=%0d exp all 0", busy16, done16, err16, res16, cyc16);
    else n_pass++;
    n_checks++;
    if ({busy8, done8, err8, res8, cyc8} !== '0)
      $display("FAIL reset8 got busy=%b done=%b err=%b res=%0d cyc=%0d exp all 0", busy8, done8, err8, res8, cyc8);
    else n_pass++;
    RESET_N = 1'b1;
  endtask

  task automatic test_single();
    bit to, mono, ovl;
    exp_t e;
    sel8 = 1'b0;
    start_job(1'b0, 59411);
    wait_done(40000, to, mono, ovl);
    e = sb.pop_front();
    n_checks++; if (to) $display("FAIL single_timeout no done within budget"); else n_pass++;
    n_checks++; if (o_res !== e.res) $display("FAIL single_result got=%0d exp=%0d", o_res, e.res); else n_pass++;
    n_checks++; if (o_err !== e.err) $display("FAIL single_error got=%b exp=%b", o_err, e.err); else n_pass++;
    n_checks++; if (o_cyc !== e.cyc) $display("FAIL single_cycles got=%0d exp=%0d", o_cyc, e.cyc); else n_pass++;
    n_checks++; if (o_busy !== 1'b0 || ovl) $display("FAIL single_busy_done got busy=%b ovl=%b exp 0", o_busy, ovl); else n_pass++;
    @(negedge CLK);
    n_checks++; if (o_done !== 1'b0) $display("FAIL single_done_width got=%b exp=0", o_done); else n_pass++;
  endtask

  task automatic test_sequence();
    int unsigned ns [3] = '{5040, 30, 1};
    logic [15:0] want [3] = '{16'd11, 16'd7, 16'd2};
    bit to, mono, ovl;
    exp_t e;
    sel8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_job(1'b0, ns[k]);
      wait_done(20000, to, mono, ovl);
      e = sb.pop_front();
      n_checks++; if (to) $display("FAIL seq_timeout n=%0d", ns[k]); else n_pass++;
      n_checks++; if (o_res !== want[k]) $display("FAIL seq_result n=%0d got=%0d exp=%0d", ns[k], o_res, want[k]); else n_pass++;
      n_checks++; if (o_err !== 1'b0) $display("FAIL seq_error n=%0d got=%b exp=0", ns[k], o_err); else n_pass++;
      n_checks++; if (o_cyc !== e.cyc) $display("FAIL seq_cycles n=%0d got=%0d exp=%0d", ns[k], o_cyc, e.cyc); else n_pass++;
    end
  endtask

  task automatic test_no_coprime();
    bit to, mono, ovl;
    exp_t e;
    sel8 = 1'b1;
    start_job(1'b1, 0);
    wait_done(3000, to, mono, ovl);
    e = sb.pop_front();
    n_checks++; if (to) $display("FAIL nocop_timeout no done"); else n_pass++;
    n_checks++; if (o_err !== 1'b1) $display("FAIL nocop_error got=%b exp=1", o_err); else n_pass++;
    n_checks++; if (o_res !== 16'd0) $display("FAIL nocop_result got=%0d exp=0", o_res); else n_pass++;
    // 254 candidates (m = 2..255), four clocks each when n = 0
    n_checks++; if (o_cyc !== 32'd1016 || o_cyc !== e.cyc) $display("FAIL nocop_cycles got=%0d exp=%0d", o_cyc, e.cyc); else n_pass++;
  endtask

  task automatic test_start_held();
    bit to, mono, ovl;
    exp_t e;
    sel8 = 1'b0;
    @(negedge CLK);
    start16 = 1'b1; n16 = 16'd30;
    sb.push_back(model(30, 16));
    @(negedge CLK);
    n16 = 16'd1000;
    wait_done(2000, to, mono, ovl);
    e = sb.pop_front();
    n_checks++; if (to) $display("FAIL held_timeout no done"); else n_pass++;
    n_checks++; if (o_res !== 16'd7 || o_res !== e.res) $display("FAIL held_result got=%0d exp=7", o_res); else n_pass++;
    n_checks++; if (o_cyc !== e.cyc) $display("FAIL held_cycles got=%0d exp=%0d", o_cyc, e.cyc); else n_pass++;
    n16 = 16'd9;
    sb.push_back(model(9, 16));
    @(negedge CLK);
    n_checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) $display("FAIL held_accept_in_done got busy=%b done=%b exp 1/0", o_busy, o_done); else n_pass++;
    start16 = 1'b0;
    n16 = 16'($urandom);
    wait_done(2000, to, mono, ovl);
    e = sb.pop_front();
    n_checks++; if (to) $display("FAIL held2_timeout no done"); else n_pass++;
    n_checks++; if (o_res !== 16'd2) $display("FAIL held2_result got=%0d exp=2", o_res); else n_pass++;
    n_checks++; if (o_cyc !== e.cyc) $display("FAIL held2_cycles got=%0d exp=%0d", o_cyc, e.cyc); else n_pass++;
  endtask

  task automatic test_reset_abort();
    bit to, mono, ovl, saw_done;
    exp_t e;
    sel8 = 1'b0;
    start_job(1'b0, 5040);
    repeat (20) @(negedge CLK);
    n_checks++; if (o_busy !== 1'b1) $display("FAIL abort_busy_before got=%b exp=1", o_busy); else n_pass++;
    #2 RESET_N = 1'b0;
    #1;
    n_checks++;
    if ({busy16, done16, err16, res16, cyc16} !== '0)
      $display("FAIL abort_async got busy=%b done=%b err=%b res=%0d cyc=%0d exp all 0", busy16, done16, err16, res16, cyc16);
    else n_pass++;
    void'(sb.pop_front());
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (done16) saw_done = 1'b1;
    end
    RESET_N = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      if (done16 || busy16) saw_done = 1'b1;
    end
    n_checks++; if (saw_done) $display("FAIL abort_no_done got activity=1 exp=0"); else n_pass++;
    start_job(1'b0, 9);
    wait_done(2000, to, mono, ovl);
    e = sb.pop_front();
    n_checks++; if (to) $display("FAIL abort_restart_timeout no done"); else n_pass++;
    n_checks++; if (o_res !== 16'd2 || o_err !== 1'b0) $display("FAIL abort_restart_result got=%0d err=%b exp=2/0", o_res, o_err); else n_pass++;
    n_checks++; if (o_cyc !== e.cyc) $display("FAIL abort_restart_cycles got=%0d exp=%0d", o_cyc, e.cyc); else n_pass++;
  endtask

  task automatic test_sweep();
    bit to, mono, ovl;
    exp_t e;
    sel8 = 1'b1;
    for (int n = 1; n <= 255; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      start_job(1'b1, n);
      wait_done(3000, to, mono, ovl);
      e = sb.pop_front();
      n_checks++; if (to) $display("FAIL sweep_timeout n=%0d", n); else n_pass++;
      n_checks++; if (o_res !== e.res || o_err !== e.err) $display("FAIL sweep_result n=%0d got=%0d/%b exp=%0d/%b", n, o_res, o_err, e.res, e.err); else n_pass++;
      n_checks++; if (o_cyc !== e.cyc) $display("FAIL sweep_cycles n=%0d got=%0d exp=%0d", n, o_cyc, e.cyc); else n_pass++;
      n_checks++; if (!mono || ovl) $display("FAIL sweep_mono_overlap n=%0d got mono=%b ovl=%b exp 1/0", n, mono, ovl); else n_pass++;
      @(negedge CLK);
      n_checks++; if (o_done !== 1'b0) $display("FAIL sweep_done_width n=%0d got=%b exp=0", n, o_done); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_no_coprime();
    test_start_held();
    test_reset_abort();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
